// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - four-way round-robin arbiter with bounded grant hold and one idle cycle between grants
module rr_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    last_id_q, last_id_d;

  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          found;
  logic          release_now;

  // Round-robin search starting just after the previous winner, previous winner last
  always_comb begin
    winner = last_id_q;
    found  = 1'b0;
    idx    = last_id_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_id_q + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // A grant ends when its owner drops, the arbiter is disabled, or the hold limit is reached
  always_comb begin
    release_now = !req[gnt_id_q] || !en || (hold_q == HW'(MAX_HOLD));
  end

  // Next-state and next-output computation; outputs are registered alongside the state
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    last_id_d = last_id_q;
    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          state_d   = S_GRANT;
          gnt_d     = 4'b0001 << winner;
          gnt_id_d  = winner;
          busy_d    = 1'b1;
          hold_d    = HW'(1);
          last_id_d = winner;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          state_d  = S_IDLE;
          gnt_d    = 4'b0000;
          gnt_id_d = 2'b00;
          busy_d   = 1'b0;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset parks last_id at 3 so requester 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'b00;
      busy_q    <= 1'b0;
      hold_q    <= '0;
      last_id_q <= 2'b11;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      last_id_q <= last_id_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - self-checking bench for rr_arb4 with a behavioural arbitration model
module tb_rr_arb4;

  localparam int MH = 8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [3:0] req2;
  logic [3:0] gnt2;
  logic [1:0] gnt_id2;
  logic       busy2;

  int checks;
  int errors;

  // model: current owner (-1 = none), cycles granted so far, last winner
  int m_cur;
  int m_cnt;
  int m_last;

  rr_arb4 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy)
  );

  rr_arb4 #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .req(req2),
    .gnt(gnt2), .gnt_id(gnt_id2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_gnt();
    return (m_cur < 0) ? 4'b0000 : (4'b0001 << m_cur);
  endfunction

  function automatic logic [1:0] m_id();
    return (m_cur < 0) ? 2'b00 : 2'(m_cur);
  endfunction

  function automatic logic m_busy();
    return (m_cur >= 0);
  endfunction

  // advance the model by the rules for the current inputs, then clock the DUT and settle
  task automatic cycle();
    bit done;
    if (rst) begin
      m_cur = -1; m_cnt = 0; m_last = 3;
    end else if (m_cur < 0) begin
      done = 0;
      if (en && req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (!done && req[c]) begin
            m_cur = c; m_cnt = 1; m_last = c; done = 1;
          end
        end
      end
    end else if (!req[m_cur] || !en || m_cnt == MH) begin
      m_cur = -1; m_cnt = 0;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'b1111; req2 = 4'b0000;
    cycle();
    cycle();
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b id=%0d busy=%b expected 0000/0/0", gnt, gnt_id, busy);
    end
    checks++;
    if (gnt2 !== 4'b0000 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs2 gnt=%b busy=%b expected 0000/0", gnt2, busy2);
    end
    rst = 1'b0;
  endtask

  task automatic test_rr_full();
    logic [3:0] exp;
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 36; i++) begin
      cycle();
      exp = ((i % 9) < 8) ? (4'b0001 << (i / 9)) : 4'b0000;
      checks++;
      if (gnt !== exp || busy !== (exp != 4'b0000)) begin
        errors++;
        $display("FAIL rr_full cycle %0d gnt=%b busy=%b expected %b", i, gnt, busy, exp);
      end
    end
    req = 4'b0000;
    cycle();
    cycle();
  endtask

  task automatic test_single();
    en = 1'b1; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_grant cycle %0d gnt=%b id=%0d busy=%b expected 0100/2/1", i, gnt, gnt_id, busy);
      end
    end
    req = 4'b0000;
    cycle();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
  endtask

  task automatic test_drop();
    en = 1'b1; req = 4'b0010;
    cycle();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL drop_setup gnt=%b expected 0010", gnt);
    end
    req = 4'b1010;
    cycle();
    req = 4'b1000;
    cycle();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    req = 4'b1010;
    cycle();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL drop_next gnt=%b id=%0d expected 1000/3", gnt, gnt_id);
    end
    for (int i = 0; i < 7; i++) cycle();
    cycle();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL drop_hold_release gnt=%b expected 0000", gnt);
    end
    cycle();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL drop_then_1 gnt=%b id=%0d expected 0010/1", gnt, gnt_id);
    end
    req = 4'b0000;
    cycle();
    cycle();
  endtask

  task automatic test_en_off();
    en = 1'b1; req = 4'b0100;
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL en_off_setup gnt=%b expected 0100", gnt);
    end
    en = 1'b0; req = 4'b1111;
    cycle();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_off_drop gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (busy !== 1'b0 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL en_off_idle cycle %0d gnt=%b busy=%b expected 0000/0", i, gnt, busy);
      end
    end
  endtask

  task automatic test_rst_mid();
    en = 1'b1; req = 4'b1000;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL rst_mid_setup gnt=%b id=%0d expected 1000/3", gnt, gnt_id);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop gnt=%b id=%0d busy=%b expected 0000/0/0", gnt, gnt_id, busy);
    end
    rst = 1'b0; req = 4'b1001;
    cycle();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_first gnt=%b id=%0d expected 0001/0", gnt, gnt_id);
    end
    req = 4'b0000;
    cycle();
    cycle();
  endtask

  task automatic test_max_hold2();
    logic [3:0] exp;
    en = 1'b1; req = 4'b0000; req2 = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      cycle();
      exp = ((i % 3) < 2) ? 4'b0001 : 4'b0000;
      checks++;
      if (gnt2 !== exp || busy2 !== (exp != 4'b0000)) begin
        errors++;
        $display("FAIL max_hold2 cycle %0d gnt=%b busy=%b expected %b", i, gnt2, busy2, exp);
      end
    end
    req2 = 4'b0000;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      cycle();
      checks++;
      if (gnt !== m_gnt() || gnt_id !== m_id() || busy !== m_busy()) begin
        errors++;
        $display("FAIL random cycle %0d gnt=%b id=%0d busy=%b expected %b/%0d/%b",
                 i, gnt, gnt_id, busy, m_gnt(), m_id(), m_busy());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_cur = -1; m_cnt = 0; m_last = 3;
    rst = 1'b1; en = 1'b0; req = 4'b0000; req2 = 4'b0000;
    test_reset();
    test_rr_full();
    test_single();
    test_drop();
    test_en_off();
    test_rst_mid();
    test_max_hold2();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
